// File: rtl/fifo_burst_sched.sv
// Drains a show-ahead FIFO as length-announced bursts: command handshake, then zero-latency beats under dat_ready_i.
// Partial bursts start on flush_i, or on an idle timeout when FIFO_BURST_SCHED_TIMEOUT_EN is defined.
module fifo_burst_sched #(
  parameter int aw        = 3,
  parameter int dw        = 8,
  parameter int burst_len = 4,
  parameter int timeout_t = 16
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [aw:0]   fifo_r_num_val_i,
  input  logic [dw-1:0] fifo_r_dout_i,
  output logic          fifo_r_en_o,
  input  logic          flush_i,
  output logic          cmd_req_o,
  output logic [aw:0]   cmd_len_o,
  input  logic          cmd_ack_i,
  output logic          dat_valid_o,
  output logic [dw-1:0] dat_o,
  output logic          dat_last_o,
  input  logic          dat_ready_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  localparam logic [aw:0] full_len = (aw+1)'(burst_len);
  localparam logic [aw:0] one      = (aw+1)'(1);

  state_t      state, state_nxt;
  logic [aw:0] beat_cnt;
  logic        has_data, full, partial, start, timeout_hit;

  assign has_data = fifo_r_num_val_i != '0;
  assign full     = fifo_r_num_val_i >= full_len;
  assign partial  = has_data && !full;

`ifdef FIFO_BURST_SCHED_TIMEOUT_EN
  localparam logic [7:0] tmr_max = 8'(timeout_t);
  logic [7:0] idle_tmr;

  assign timeout_hit = idle_tmr == tmr_max;

  // Counts only while a partial burst waits in IDLE; any other condition restarts the wait.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idle_tmr <= '0;
    end else if (state == IDLE && partial && state_nxt == IDLE) begin
      idle_tmr <= timeout_hit ? idle_tmr : idle_tmr + 8'd1;
    end else begin
      idle_tmr <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy_o      = state != IDLE;
  assign cmd_req_o   = state == REQ;
  assign dat_valid_o = (state == XFER) && has_data;
  assign dat_o       = (state == XFER) ? fifo_r_dout_i : '0;
  assign fifo_r_en_o = dat_valid_o && dat_ready_i;
  assign dat_last_o  = dat_valid_o && (beat_cnt == one);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (full || (partial && (flush_i || timeout_hit))) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (cmd_ack_i) state_nxt = XFER;
      end
      XFER: begin
        if (fifo_r_en_o && beat_cnt == one) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      cmd_len_o <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start) cmd_len_o <= full ? full_len : fifo_r_num_val_i;
      // Beat count is armed from the latched length so a burst can never overrun it.
      if (state == REQ && cmd_ack_i) begin
        beat_cnt <= cmd_len_o;
      end else if (fifo_r_en_o) begin
        beat_cnt <= beat_cnt - one;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed bench for fifo_burst_sched with a show-ahead FIFO model; honours FIFO_BURST_SCHED_TIMEOUT_EN.
module tb_fifo_burst_sched;
  localparam int aw = 3, dw = 8, burst_len = 4, timeout_t = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [aw:0]   num;
  logic [dw-1:0] dout;
  logic          rd_en;
  logic          flush = 1'b0;
  logic          req;
  logic [aw:0]   len;
  logic          ack = 1'b0;
  logic          valid;
  logic [dw-1:0] dat;
  logic          last;
  logic          ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_sched #(.aw(aw), .dw(dw), .burst_len(burst_len), .timeout_t(timeout_t)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .fifo_r_num_val_i(num), .fifo_r_dout_i(dout), .fifo_r_en_o(rd_en),
    .flush_i(flush),
    .cmd_req_o(req), .cmd_len_o(len), .cmd_ack_i(ack),
    .dat_valid_o(valid), .dat_o(dat), .dat_last_o(last), .dat_ready_i(ready),
    .busy_o(busy)
  );

  // Show-ahead FIFO model, not cleared by the scheduler reset.
  logic [7:0] mem [8];
  logic [2:0] rp = '0, wp = '0;
  logic [3:0] cnt = '0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_dat = '0;
  int         bulk_n = 0;
  logic [7:0] bulk_base = '0;
  int         pops = 0;

  always @(posedge clk) begin
    if (rd_en) begin
      rp   <= rp + 3'd1;
      pops <= pops + 1;
    end
    if (wr_en) begin
      mem[wp] <= wr_dat;
      wp      <= wp + 3'd1;
    end
    for (int i = 0; i < bulk_n; i++) mem[3'(wp + i)] <= bulk_base + 8'(i);
    if (bulk_n > 0) wp <= wp + 3'(bulk_n);
    cnt <= cnt + 4'(wr_en) + 4'(bulk_n) - 4'(rd_en);
  end

  assign num  = cnt;
  assign dout = mem[rp];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en  = 1'b1;
    wr_dat = b;
    cyc();
    wr_en  = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int k);
    k = 0;
    while (!req && k < limit) begin
      cyc();
      k++;
    end
  endtask

  // Ack is raised one cycle after the request is first seen.
  task automatic do_ack(input logic [aw:0] exp_len);
    cyc();
    check("req_hold", req, 1);
    check("len_hold", len, exp_len);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  task automatic xfer(input int exp_len, input logic [7:0] first, input bit toggle, input int stop_after);
    int beats = 0;
    int p0 = pops;
    for (int c = 0; c < 40 && beats < stop_after; c++) begin
      ready = toggle ? ((c % 2) == 0) : 1'b1;
      #1;
      check("xfer_valid", valid, 1);
      check("xfer_ren", rd_en, ready);
      if (ready) begin
        check("xfer_dat", dat, first + beats);
        check("xfer_last", last, beats == exp_len - 1);
        beats++;
      end
      cyc();
    end
    check("xfer_beats", beats, stop_after);
    if (stop_after == exp_len) begin
      check("xfer_done_busy", busy, 0);
      check("xfer_pops", pops - p0, exp_len);
    end
  endtask

  initial begin
    int k;
    int beat;
    logic [13:0] req_pat, val_pat, last_pat;

    #2;
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_len", len, 0);
    cyc();
    reset_n = 1'b1;
    ready   = 1'b1;

    // Full burst of four consecutive beats.
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    wait_req(20, k);
    check("t1_req_wait", k, 1);
    check("t1_len", len, 4);
    do_ack(4);
    xfer(4, 8'h11, 1'b0, 4);
    check("t1_empty", num, 0);

    // Two lines, no flush: timer counts from the first line, so req appears 8 cycles after the second.
    push(8'h21);
    push(8'h22);
    wait_req(100, k);
`ifdef FIFO_BURST_SCHED_TIMEOUT_EN
    check("t2_timeout_wait", k, 8);
`else
    check("t2_no_req", req, 0);
    check("t2_no_busy", busy, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
`endif
    check("t2_req", req, 1);
    check("t2_len", len, 2);
    do_ack(2);
    xfer(2, 8'h21, 1'b0, 2);

    // Single line drained by a flush pulse.
    push(8'h31);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_req(5, k);
    check("t3_req_wait", k, 0);
    check("t3_len", len, 1);
    do_ack(1);
    xfer(1, 8'h31, 1'b0, 1);

    // Full burst under alternating ready.
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    wait_req(20, k);
    check("t4_req_wait", k, 1);
    do_ack(4);
    xfer(4, 8'h41, 1'b1, 4);

    // Reset after two of four beats, then flush out the remainder.
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
    wait_req(20, k);
    do_ack(4);
    xfer(4, 8'h51, 1'b0, 2);
    check("t5_mid_valid", valid, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", valid, 0);
    check("t5_rst_ren", rd_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_len", len, 0);
    check("t5_rst_last", last, 0);
    check("t5_rst_dat", dat, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    flush   = 1'b1;
    cyc();
    flush = 1'b0;
    check("t5_req", req, 1);
    check("t5_len", len, 2);
    do_ack(2);
    xfer(2, 8'h53, 1'b0, 2);

    // Eight lines, ack held high: two bursts separated by one IDLE cycle, flush ignored mid-burst.
    req_pat  = 14'h0082;
    val_pat  = 14'h0F3C;
    last_pat = 14'h0820;
    ack       = 1'b1;
    ready     = 1'b1;
    bulk_base = 8'h61;
    bulk_n    = 8;
    cyc();
    bulk_n = 0;
    beat   = 0;
    for (int c = 0; c < 14; c++) begin
      flush = (c == 3) || (c == 9);
      #1;
      check("t6_req", req, req_pat[c]);
      check("t6_valid", valid, val_pat[c]);
      check("t6_busy", busy, req_pat[c] | val_pat[c]);
      if (val_pat[c]) begin
        check("t6_dat", dat, 8'h61 + 8'(beat));
        check("t6_last", last, last_pat[c]);
        beat++;
      end
      if (c == 7) check("t6_len2", len, 4);
      cyc();
    end
    flush = 1'b0;
    ack   = 1'b0;
    check("t6_empty", num, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
